// File: rtl/fd_pkg.sv
// Shared definitions for the programmable frequency divider.
// - CNT_W_DEF : default width of ratio and counter
// - mode_e    : output waveform encodings
// - idle_level: level of div_o while the divider is disabled
package fd_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_PLO = 2'b00,  // one low cycle per period
    MODE_D50 = 2'b01,  // ~50% duty, high half rounded up
    MODE_PHI = 2'b10,  // one high cycle per period
    MODE_RSV = 2'b11   // reserved, behaves as MODE_PLO
  } mode_e;

  // Only pulse-high mode idles low; every other mode idles high.
  function automatic logic idle_level(input logic [1:0] m);
    return (m != MODE_PHI);
  endfunction

endpackage

// File: rtl/fd_prog_div_if.sv
// Counter status bus between the divider top and its counter.
// - m_act : shadowed ratio (top -> counter)
// - ratio : effective ratio after clamping to >= 2 (counter -> top)
// - cnt   : current count (counter -> top)
// - last  : cnt is at ratio-1, i.e. the final cycle of a period
// Signals are level-valued every cycle; there is no valid/ready handshake.
interface fd_prog_div_if
  import fd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [CNT_W-1:0] m_act;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] cnt;
  logic             last;

  modport master (output m_act, input ratio, input cnt, input last);
  modport slave  (input m_act, output ratio, output cnt, output last);
endinterface

// File: rtl/fd_cnt.sv
// Period counter: clamps the ratio, counts 0..R-1 while enabled and flags
// the final cycle of each period.
// Ports:
// - clk_ext, rst_n : clock, async active-low reset
// - en             : run enable; count is held at 0 while low
// - cbus           : status bus (slave side)
module fd_cnt
  import fd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk_ext,
  input  logic          rst_n,
  input  logic          en,
  fd_prog_div_if.slave  cbus
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Ratios below 2 cannot form a period with both output phases.
  assign cbus.ratio = (cbus.m_act < CNT_W'(2)) ? CNT_W'(2) : cbus.m_act;
  // ratio >= 2, so ratio-1 never underflows and cnt never exceeds it.
  assign cbus.last  = (cnt_q == (cbus.ratio - CNT_W'(1)));
  assign cbus.cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || cbus.last) cnt_d = '0;
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fd_prog_div.sv
// Programmable clock divider with glitch-free ratio/mode update.
// Ports:
// - clk_ext : clock; rst_n : async active-low reset
// - en      : run enable
// - m_in    : requested ratio, sampled while disabled or at period end
// - mode    : requested waveform, sampled with m_in
// - div_o   : registered divided output
// - wrap_o  : registered one-cycle strobe, one per period
// - cnt_o   : current count, no extra latency
module fd_prog_div
  import fd_pkg::*;
#(
  parameter int         CNT_W    = CNT_W_DEF,
  parameter logic [1:0] RST_MODE = 2'b00
) (
  input  logic             clk_ext,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] m_in,
  input  logic [1:0]       mode,
  output logic             div_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] cnt_o
);

  fd_prog_div_if #(.CNT_W(CNT_W)) cbus ();

  fd_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .en      (en),
    .cbus    (cbus)
  );

  logic [CNT_W-1:0] m_act_q, m_act_d;
  logic [1:0]       mode_act_q, mode_act_d;
  logic             div_q, div_d;
  logic             wrap_q, wrap_d;
  logic             load;
  logic [CNT_W:0]   half_hi;

  assign cbus.m_act = m_act_q;

  // ceil(R/2) in one extra bit so R = 2^CNT_W-1 cannot overflow.
  assign half_hi = ({1'b0, cbus.ratio} + (CNT_W+1)'(1)) >> 1;

  always_comb begin
    // Shadows only move between periods, so a period never mixes settings.
    load       = !en || cbus.last;
    m_act_d    = load ? m_in : m_act_q;
    mode_act_d = load ? mode : mode_act_q;
    wrap_d     = en && cbus.last;
    div_d      = idle_level(mode_act_q);
    if (en) begin
      case (mode_act_q)
        MODE_D50: div_d = ({1'b0, cbus.cnt} < half_hi);
        MODE_PHI: div_d = cbus.last;
        default:  div_d = !cbus.last;
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      m_act_q    <= CNT_W'(2);
      mode_act_q <= RST_MODE;
      wrap_q     <= 1'b0;
      div_q      <= idle_level(RST_MODE);
    end else begin
      m_act_q    <= m_act_d;
      mode_act_q <= mode_act_d;
      wrap_q     <= wrap_d;
      div_q      <= div_d;
    end
  end

  assign div_o  = div_q;
  assign wrap_o = wrap_q;
  assign cnt_o  = cbus.cnt;

endmodule

// File: tb/tb_fd_prog_div.sv
// Bench for fd_prog_div: directed scenarios with literal expectations plus a
// period-level reference model compared on every falling clock edge.
module tb_fd_prog_div;
  import fd_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk_ext = 1'b0;
  logic         rst_n   = 1'b1;
  logic         en      = 1'b0;
  logic [W-1:0] m_in    = 4'd3;
  logic [1:0]   mode    = 2'b00;
  logic         div_o, wrap_o;
  logic [W-1:0] cnt_o;

  always #5 clk_ext = ~clk_ext;

  fd_prog_div #(.CNT_W(W), .RST_MODE(2'b00)) dut (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .en      (en),
    .m_in    (m_in),
    .mode    (mode),
    .div_o   (div_o),
    .wrap_o  (wrap_o),
    .cnt_o   (cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks position within the current period and the settings that period
  // was started with; outputs follow from the waveform rules.
  int md_pos  = 0;
  int md_m    = 2;
  int md_mode = 0;
  bit md_div  = 1'b1;
  bit md_wrap = 1'b0;

  always @(posedge clk_ext or negedge rst_n) begin
    int  r;
    bit  fin;
    if (!rst_n) begin
      md_pos = 0; md_m = 2; md_mode = 0; md_wrap = 0; md_div = 1;
    end else if (!en) begin
      md_div  = (md_mode != 2);
      md_wrap = 0;
      md_pos  = 0;
      md_m    = int'(m_in);
      md_mode = int'(mode);
    end else begin
      r       = (md_m < 2) ? 2 : md_m;
      fin     = (md_pos == r - 1);
      md_wrap = fin;
      if (md_mode == 1)      md_div = (md_pos < (r + 1) / 2);
      else if (md_mode == 2) md_div = fin;
      else                   md_div = !fin;
      if (fin) begin
        md_pos  = 0;
        md_m    = int'(m_in);
        md_mode = int'(mode);
      end else begin
        md_pos  = md_pos + 1;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_ext) begin
    chk("model_cnt",  64'(cnt_o),  64'(md_pos));
    chk("model_div",  64'(div_o),  64'(md_div));
    chk("model_wrap", 64'(wrap_o), 64'(md_wrap));
  end

  // ---------------- driver tasks ----------------
  task automatic setup(input logic [W-1:0] m, input logic [1:0] md);
    @(posedge clk_ext); #1;
    en = 1'b0; m_in = m; mode = md;
    repeat (2) @(posedge clk_ext);
    #1 en = 1'b1;
  endtask

  // Collects n post-edge samples, oldest in the most significant position.
  task automatic sample_n(input int n, output logic [31:0] dv,
                          output logic [31:0] wr, output logic [63:0] cn);
    dv = '0; wr = '0; cn = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ext);
      @(negedge clk_ext);
      dv = {dv[30:0], div_o};
      wr = {wr[30:0], wrap_o};
      cn = {cn[59:0], cnt_o};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] dv, wr;
    logic [63:0] cn;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_cnt",  64'(cnt_o),  64'd0);
    chk("rst_div",  64'(div_o),  64'd1);
    chk("rst_wrap", 64'(wrap_o), 64'd0);
    repeat (2) @(posedge clk_ext);
    #1 rst_n = 1'b1;

    // pulse-low, R=3
    setup(4'd3, 2'b00);
    sample_n(6, dv, wr, cn);
    chk("plo3_div",  64'(dv), 64'b110110);
    chk("plo3_wrap", 64'(wr), 64'b001001);
    chk("plo3_cnt",  cn, 64'h120120);

    // reserved mode behaves as pulse-low
    setup(4'd3, 2'b11);
    sample_n(3, dv, wr, cn);
    chk("rsv3_div", 64'(dv), 64'b110);

    // duty-50, R=5 then R=4
    setup(4'd5, 2'b01);
    sample_n(10, dv, wr, cn);
    chk("d50_5_div",  64'(dv), 64'b1110011100);
    chk("d50_5_wrap", 64'(wr), 64'b0000100001);
    setup(4'd4, 2'b01);
    sample_n(8, dv, wr, cn);
    chk("d50_4_div", 64'(dv), 64'b11001100);
    chk("d50_4_cnt", cn, 64'h12301230);

    // clamp: 0,1,2 all give period 2
    for (int m = 0; m < 3; m++) begin
      setup(W'(m), 2'b00);
      sample_n(4, dv, wr, cn);
      chk($sformatf("clamp%0d_div", m),  64'(dv), 64'b1010);
      chk($sformatf("clamp%0d_wrap", m), 64'(wr), 64'b0101);
      chk($sformatf("clamp%0d_cnt", m),  cn, 64'h1010);
    end

    // ratio change mid-period at cnt=2
    setup(4'd6, 2'b00);
    sample_n(2, dv, wr, cn);
    chk("mid_pre_cnt", cn, 64'h12);
    m_in = 4'd3;
    sample_n(10, dv, wr, cn);
    chk("mid_div", 64'(dv), 64'b1110110110);
    chk("mid_cnt", cn, 64'h3450120120);

    // enable drop at cnt=4 in pulse-high mode
    setup(4'd7, 2'b10);
    sample_n(4, dv, wr, cn);
    chk("endrop_pre_cnt", cn, 64'h1234);
    chk("endrop_pre_div", 64'(dv), 64'b0000);
    en = 1'b0;
    sample_n(1, dv, wr, cn);
    chk("endrop_cnt",  cn, 64'h0);
    chk("endrop_div",  64'(dv), 64'b0);
    chk("endrop_wrap", 64'(wr), 64'b0);
    en = 1'b1;
    sample_n(7, dv, wr, cn);
    chk("reen_cnt", cn, 64'h1234560);
    chk("reen_div", 64'(dv), 64'b0000001);

    // async reset mid-period
    setup(4'd5, 2'b01);
    sample_n(3, dv, wr, cn);
    chk("arst_pre_cnt", cn, 64'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt",  64'(cnt_o),  64'd0);
    chk("arst_div",  64'(div_o),  64'd1);
    chk("arst_wrap", 64'(wrap_o), 64'd0);
    @(posedge clk_ext);
    #1 rst_n = 1'b1;
    sample_n(7, dv, wr, cn);
    chk("arst_post_cnt",  cn, 64'h1012340);
    chk("arst_post_div",  64'(dv), 64'b1011100);
    chk("arst_post_wrap", 64'(wr), 64'b0100001);

    @(posedge clk_ext);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
